// File: rtl/softex_tcdm_responder.sv
// Multi-port TCDM slave: MP word-interleaved 64-bit banks, fixed-priority bank arbitration, 2-entry response FIFO per port.
// Optional random grant stalls are compiled in with `define SOFTEX_TCDM_STALL_EN.
module softex_tcdm_responder #(
    parameter int unsigned MP    = 4,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDW   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [MP-1:0]            tcdm_req_i,
    output logic [MP-1:0]            tcdm_gnt_o,
    input  logic [MP-1:0][31:0]      tcdm_add_i,
    input  logic [MP-1:0]            tcdm_wen_i,
    input  logic [MP-1:0][7:0]       tcdm_be_i,
    input  logic [MP-1:0][63:0]      tcdm_data_i,
    input  logic [MP-1:0][IDW-1:0]   tcdm_id_i,
    input  logic [MP-1:0]            tcdm_r_ready_i,
    output logic [MP-1:0]            tcdm_r_valid_o,
    output logic [MP-1:0][63:0]      tcdm_r_data_o,
    output logic [MP-1:0][IDW-1:0]   tcdm_r_id_o
);

    localparam int unsigned LOG_MP = $clog2(MP);
    localparam int unsigned BANK_W = (MP > 1) ? LOG_MP : 1;
    localparam int unsigned ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW     = 64;

    logic [BANK_W-1:0] bank    [MP];
    logic [ROW_W-1:0]  row     [MP];
    logic [DW-1:0]     mem     [MP][DEPTH];
    logic [DW-1:0]     rd_data [MP];
    logic [MP-1:0]     win;
    logic [MP-1:0]     stall;
    logic [MP-1:0]     push;
    logic [MP-1:0]     pop;
    logic [MP-1:0]     valid;
    logic [1:0]        cnt     [MP];
    logic [MP-1:0]     wptr;
    logic [MP-1:0]     rptr;
    logic [DW-1:0]     fifo_data [MP][2];
    logic [IDW-1:0]    fifo_id   [MP][2];

    // Address decode, pre-write bank read, and lowest-index-wins arbitration per bank
    always_comb begin
        for (int p = 0; p < int'(MP); p++) begin
            bank[p]    = BANK_W'((tcdm_add_i[p] >> 3) & 32'(MP - 1));
            row[p]     = ROW_W'((tcdm_add_i[p] >> (3 + LOG_MP)) & 32'(DEPTH - 1));
            rd_data[p] = mem[bank[p]][row[p]];
        end
        for (int p = 0; p < int'(MP); p++) begin
            win[p] = tcdm_req_i[p];
            for (int q = 0; q < p; q++) begin
                if (tcdm_req_i[q] && (bank[q] == bank[p])) begin
                    win[p] = 1'b0;
                end
            end
        end
    end

`ifdef SOFTEX_TCDM_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        for (int p = 0; p < int'(MP); p++) begin
            stall[p] = (lfsr[2*p +: 2] == 2'b00);
        end
    end
`else
    assign stall = '0;
`endif

    // Grant is combinational; a full FIFO blocks even if a pop happens this cycle
    always_comb begin
        for (int p = 0; p < int'(MP); p++) begin
            tcdm_gnt_o[p]     = win[p] && (cnt[p] != 2'd2) && !stall[p] && !rst_i;
            push[p]           = tcdm_gnt_o[p];
            valid[p]          = (cnt[p] != 2'd0);
            pop[p]            = valid[p] && tcdm_r_ready_i[p];
            tcdm_r_valid_o[p] = valid[p] && !rst_i;
            tcdm_r_data_o[p]  = tcdm_r_valid_o[p] ? fifo_data[p][rptr[p]] : '0;
            tcdm_r_id_o[p]    = tcdm_r_valid_o[p] ? fifo_id[p][rptr[p]]   : '0;
        end
    end

    // Byte-masked bank writes; granted ports never share a bank
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < int'(MP); p++) begin
            if (tcdm_gnt_o[p] && !tcdm_wen_i[p]) begin
                for (int k = 0; k < 8; k++) begin
                    if (tcdm_be_i[p][k]) begin
                        mem[bank[p]][row[p]][8*k +: 8] <= tcdm_data_i[p][8*k +: 8];
                    end
                end
            end
        end
    end

    // Per-port 2-entry response FIFO
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < int'(MP); p++) begin
                cnt[p] <= 2'd0;
            end
            wptr <= '0;
            rptr <= '0;
        end else begin
            for (int p = 0; p < int'(MP); p++) begin
                if (push[p]) begin
                    fifo_data[p][wptr[p]] <= tcdm_wen_i[p] ? rd_data[p] : '0;
                    fifo_id[p][wptr[p]]   <= tcdm_id_i[p];
                    wptr[p]               <= ~wptr[p];
                end
                if (pop[p]) begin
                    rptr[p] <= ~rptr[p];
                end
                if (push[p] && !pop[p]) begin
                    cnt[p] <= cnt[p] + 2'd1;
                end else if (pop[p] && !push[p]) begin
                    cnt[p] <= cnt[p] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Directed bench for softex_tcdm_responder (default build, MP=4): reset, write/read, byte enables, bank conflict, backpressure, mid-transaction reset.
module tb_softex_tcdm_responder;

    localparam int unsigned MP  = 4;
    localparam int unsigned IDW = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [MP-1:0]          req;
    logic [MP-1:0]          gnt;
    logic [MP-1:0][31:0]    add;
    logic [MP-1:0]          wen;
    logic [MP-1:0][7:0]     be;
    logic [MP-1:0][63:0]    data;
    logic [MP-1:0][IDW-1:0] id;
    logic [MP-1:0]          r_ready;
    logic [MP-1:0]          r_valid;
    logic [MP-1:0][63:0]    r_data;
    logic [MP-1:0][IDW-1:0] r_id;

    int checks = 0;
    int errors = 0;

    softex_tcdm_responder #(.MP(MP), .DEPTH(1024), .IDW(IDW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tcdm_req_i     (req),
        .tcdm_gnt_o     (gnt),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_be_i      (be),
        .tcdm_data_i    (data),
        .tcdm_id_i      (id),
        .tcdm_r_ready_i (r_ready),
        .tcdm_r_valid_o (r_valid),
        .tcdm_r_data_o  (r_data),
        .tcdm_r_id_o    (r_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic w,
                            input logic [7:0] b, input logic [63:0] d, input logic [IDW-1:0] i);
        add[p]  = a;
        wen[p]  = w;
        be[p]   = b;
        data[p] = d;
        id[p]   = i;
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        req     = '1;
        r_ready = '1;
        for (int p = 0; p < int'(MP); p++) begin
            set_port(p, 32'(p * 8), 1'b1, 8'hFF, 64'h0, IDW'(p));
        end

        // Reset held for 3 cycles with all ports requesting
        for (int c = 0; c < 3; c++) begin
            next_cycle(); #1;
            chk("rst_gnt", 64'(gnt), 64'h0);
            chk("rst_rvalid", 64'(r_valid), 64'h0);
            chk("rst_rdata0", r_data[0], 64'h0);
        end

        // First cycle out of reset grants all four (distinct banks)
        next_cycle(); rst = 1'b0; #1;
        chk("post_rst_gnt", 64'(gnt), 64'hF);
        next_cycle(); req = '0; #1;
        chk("post_rst_rvalid", 64'(r_valid), 64'hF);
        chk("post_rst_rid2", 64'(r_id[2]), 64'h2);
        next_cycle(); #1;
        chk("post_rst_drain", 64'(r_valid), 64'h0);

        // Write then read back on port 0
        next_cycle(); req = 4'b0001; set_port(0, 32'h40, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'h01); #1;
        chk("wr_gnt", 64'(gnt), 64'h1);
        next_cycle(); set_port(0, 32'h40, 1'b1, 8'hFF, 64'h0, 8'h05); #1;
        chk("rd_gnt", 64'(gnt), 64'h1);
        chk("wr_rsp_valid", 64'(r_valid), 64'h1);
        chk("wr_rsp_data", r_data[0], 64'h0);
        chk("wr_rsp_id", 64'(r_id[0]), 64'h01);
        next_cycle(); req = '0; #1;
        chk("rd_rsp_data", r_data[0], 64'h0123_4567_89AB_CDEF);
        chk("rd_rsp_id", 64'(r_id[0]), 64'h05);

        // Partial byte enables
        next_cycle(); req = 4'b0001; set_port(0, 32'h40, 1'b0, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 8'h02); #1;
        chk("be_wr_gnt", 64'(gnt), 64'h1);
        next_cycle(); set_port(0, 32'h40, 1'b1, 8'h00, 64'h0, 8'h06); #1;
        chk("be_wr_rsp_id", 64'(r_id[0]), 64'h02);
        next_cycle(); req = '0; #1;
        chk("be_rd_data", r_data[0], 64'h0123_4567_FFFF_FFFF);
        chk("be_rd_id", 64'(r_id[0]), 64'h06);

        // Bank conflict, writes: ports 1 and 3 both hit bank 1
        next_cycle(); req = 4'b1010;
        set_port(1, 32'h08, 1'b0, 8'hFF, 64'hAAAA_0000_1111_2222, 8'h11);
        set_port(3, 32'h28, 1'b0, 8'hFF, 64'hBBBB_3333_4444_5555, 8'h33); #1;
        chk("cf_wr_gnt1", 64'(gnt), 64'h2);
        next_cycle(); req = 4'b1000; #1;
        chk("cf_wr_gnt2", 64'(gnt), 64'h8);
        chk("cf_wr_rvalid1", 64'(r_valid), 64'h2);
        chk("cf_wr_rid1", 64'(r_id[1]), 64'h11);
        next_cycle(); req = '0; #1;
        chk("cf_wr_rvalid3", 64'(r_valid), 64'h8);
        chk("cf_wr_rid3", 64'(r_id[3]), 64'h33);

        // Bank conflict, reads of the same locations
        next_cycle(); req = 4'b1010;
        set_port(1, 32'h08, 1'b1, 8'h00, 64'h0, 8'h21);
        set_port(3, 32'h28, 1'b1, 8'h00, 64'h0, 8'h23); #1;
        chk("cf_rd_gnt1", 64'(gnt), 64'h2);
        next_cycle(); req = 4'b1000; #1;
        chk("cf_rd_gnt2", 64'(gnt), 64'h8);
        chk("cf_rd_data1", r_data[1], 64'hAAAA_0000_1111_2222);
        chk("cf_rd_id1", 64'(r_id[1]), 64'h21);
        next_cycle(); req = '0; #1;
        chk("cf_rd_data3", r_data[3], 64'hBBBB_3333_4444_5555);
        chk("cf_rd_id3", 64'(r_id[3]), 64'h23);

        // Backpressure on port 2: three reads with r_ready low
        next_cycle(); r_ready = 4'b1011; req = 4'b0100; set_port(2, 32'h40, 1'b1, 8'h00, 64'h0, 8'h31); #1;
        chk("bp_gnt_a", 64'(gnt), 64'h4);
        next_cycle(); set_port(2, 32'h08, 1'b1, 8'h00, 64'h0, 8'h32); #1;
        chk("bp_gnt_b", 64'(gnt), 64'h4);
        next_cycle(); set_port(2, 32'h28, 1'b1, 8'h00, 64'h0, 8'h33); #1;
        chk("bp_full_gnt", 64'(gnt), 64'h0);
        chk("bp_head_id", 64'(r_id[2]), 64'h31);
        next_cycle(); #1;
        chk("bp_hold_gnt", 64'(gnt), 64'h0);
        chk("bp_hold_data", r_data[2], 64'h0123_4567_FFFF_FFFF);
        chk("bp_hold_id", 64'(r_id[2]), 64'h31);
        next_cycle(); r_ready = '1; #1;
        chk("bp_pop_cycle_gnt", 64'(gnt), 64'h0);
        next_cycle(); #1;
        chk("bp_after_pop_gnt", 64'(gnt), 64'h4);
        chk("bp_second_data", r_data[2], 64'hAAAA_0000_1111_2222);
        chk("bp_second_id", 64'(r_id[2]), 64'h32);
        next_cycle(); req = '0; #1;
        chk("bp_third_data", r_data[2], 64'hBBBB_3333_4444_5555);
        chk("bp_third_id", 64'(r_id[2]), 64'h33);
        next_cycle(); #1;
        chk("bp_drained", 64'(r_valid), 64'h0);

        // Reset with pending responses and a write presented during reset
        next_cycle(); r_ready = 4'b1011; req = 4'b0100; set_port(2, 32'h40, 1'b1, 8'h00, 64'h0, 8'h41); #1;
        chk("mr_gnt_a", 64'(gnt), 64'h4);
        next_cycle(); set_port(2, 32'h08, 1'b1, 8'h00, 64'h0, 8'h42); #1;
        chk("mr_gnt_b", 64'(gnt), 64'h4);
        next_cycle(); rst = 1'b1; req = 4'b0001;
        set_port(0, 32'h40, 1'b0, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 8'h09); #1;
        chk("mr_rst_gnt", 64'(gnt), 64'h0);
        chk("mr_rst_rvalid", 64'(r_valid), 64'h0);
        next_cycle(); rst = 1'b0; r_ready = '1; set_port(0, 32'h40, 1'b1, 8'h00, 64'h0, 8'h07); #1;
        chk("mr_flushed", 64'(r_valid), 64'h0);
        chk("mr_rd_gnt", 64'(gnt), 64'h1);
        next_cycle(); req = '0; #1;
        chk("mr_rvalid", 64'(r_valid), 64'h1);
        chk("mr_data_kept", r_data[0], 64'h0123_4567_FFFF_FFFF);
        chk("mr_id", 64'(r_id[0]), 64'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
